stepper_move_seq: RTL and testbench
===================================

// Module: stepper_move_seq
// PURPOSE
//  Move sequencer for the stepper drive: accepts move commands (dir, step count,
//  step period) over valid/ready, drives direct and step_out with fixed setup and
//  pulse timing, stops early on limit-switch (jockey_l/jockey_r, active-low) or abort.
//  Sits between the key/state control logic and the motor driver pins.
// PARAMETERS
//  CNT_W     16  width of step count and step_cnt
//  PER_W     16  width of step period (sclk cycles between step rising edges)
//  SETUP_CYC 4   cycles direct is stable before first step pulse (>=1)
//  PULSE_W   2   step_out high time in cycles (>=1)
// PORTS
//  sclk        in   1      system clock
//  s_rst       in   1      synchronous reset, active-high
//  cmd_valid   in   1      move command valid
//  cmd_ready   out  1      sequencer can accept a command (IDLE only)
//  cmd_dir     in   1      1 = toward jockey_r, 0 = toward jockey_l
//  cmd_steps   in   CNT_W  number of step pulses
//  cmd_period  in   PER_W  rising-edge spacing; values < PULSE_W+1 clamp to PULSE_W+1
//  abort       in   1      level; ends active move at next safe point
//  jockey_l    in   1      left limit switch, 0 = hit (async, synchronised inside)
//  jockey_r    in   1      right limit switch, 0 = hit (async, synchronised inside)
//  direct      out  1      direction to driver
//  step_out    out  1      step pulse to driver
//  busy        out  1      move in progress (SETUP/STEP_HI/STEP_LO)
//  done        out  1      1-cycle pulse at end of every accepted command
//  status      out  2      valid with done, held until next accept: 00 OK, 01 LIMIT, 10 ABORT
//  step_cnt    out  CNT_W  pulses issued in current/last move
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: all outputs 0 (cmd_ready=0 while s_rst=1, 1 first cycle after); FSM->IDLE.
//   Reset mid-move: step_out low next edge, no done pulse, step_cnt cleared.
//  Limits pass a 2-flop synchroniser; "limit active" = synced switch in direct's direction.
//  FSM: IDLE, SETUP, STEP_HI, STEP_LO, DONE. All outputs registered.
//  IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready at edge T: latch steps/period,
//   step_cnt<=0, direct<=cmd_dir, status<=00.
//   - cmd_steps==0 -> DONE at T+1, status 00, no pulses.
//   - limit in cmd_dir already active -> DONE at T+1, status 01, no pulses.
//   - else SETUP at T+1 (busy=1). abort in IDLE ignored; abort+cmd_valid same cycle: accept.
//  SETUP: SETUP_CYC cycles, then STEP_HI. First step_out rise at T+SETUP_CYC+1.
//  STEP_HI: step_out=1 for PULSE_W cycles; step_cnt++ on entry; never truncated by limit/abort.
//  STEP_LO: step_out=0 for period-PULSE_W cycles; then STEP_HI if pulses remain, else DONE (00).
//  abort sets a pending flag in any busy state; pending abort or active limit, checked each
//   cycle in SETUP/STEP_LO -> DONE next cycle. Abort has priority (status 10) over limit (01).
//  DONE: 1 cycle, done=1, busy=0, cmd_ready=0; next cycle IDLE. direct holds last value.
//  Counters: remaining-steps down-counter CNT_W bits, period timer PER_W bits; no wrap
//   (max move 2^CNT_W-1 steps).
// TESTING
//  Reset: s_rst=1 5 cycles, release -> all outputs 0, cmd_ready=1 one cycle after release.
//  Normal: dir=1, steps=3, period=5, accept cycle 0 -> step_out high 5-6,10-11,15-16;
//   done cycle 20, status 00, step_cnt 3, direct=1 from cycle 1.
//  Clamp/zero: period=1, steps=2 -> rises 3 cycles apart; steps=0 -> done at cycle 1, no pulse.
//  Limit: dir=1, steps=10, period=5, jockey_r=0 at cycle 12 -> no rise after cycle 10,
//   done within 4 cycles of sync, status 01, step_cnt 2; jockey_l toggling has no effect.
//  Start on limit: jockey_l=0, dir=0 command -> done cycle 1, status 01, step_out never high.
//  Abort: abort=1 during STEP_HI of pulse 2 -> pulse completes full PULSE_W, no pulse 3,
//   status 10; s_rst during STEP_HI -> step_out 0 next cycle, no done.

Source files
------------

// File: rtl/stepper_move_seq.sv
// stepper_move_seq: move sequencer for a step/direction motor driver.
// Takes one move command at a time (direction, step count, step period) over a
// valid/ready handshake. It holds the direction line stable for a setup window,
// then emits fixed-width step pulses at the requested spacing. A move ends early
// on a limit switch in the direction of travel, or on an abort request.
// All outputs are registered.
module stepper_move_seq #(
  parameter int CNT_W     = 16,
  parameter int PER_W     = 16,
  parameter int SETUP_CYC = 4,
  parameter int PULSE_W   = 2
) (
  input  logic             sclk,
  input  logic             s_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             abort,
  input  logic             jockey_l,
  input  logic             jockey_r,
  output logic             direct,
  output logic             step_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] step_cnt
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_STEP_HI = 3'd2;
  localparam logic [2:0] ST_STEP_LO = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Completion codes reported on status
  localparam logic [1:0] STAT_OK    = 2'b00;
  localparam logic [1:0] STAT_LIMIT = 2'b01;
  localparam logic [1:0] STAT_ABORT = 2'b10;

  // Timer reload values. Each phase counts down to zero, so loads are length-1.
  // The shortest legal period leaves at least one low cycle between pulses.
  localparam logic [PER_W-1:0] MIN_PERIOD = PER_W'(PULSE_W + 1);
  localparam logic [PER_W-1:0] SETUP_LOAD = PER_W'(SETUP_CYC - 1);
  localparam logic [PER_W-1:0] PULSE_LOAD = PER_W'(PULSE_W - 1);
  localparam logic [PER_W-1:0] LO_BIAS    = PER_W'(PULSE_W + 1);

  // ---------------------------------------------------------------------------
  // Limit switch synchronisers. Index 0 = left switch, 1 = right switch.
  // The switches are active-low. The flops reset to "released", so that reset
  // never creates a phantom limit.
  // ---------------------------------------------------------------------------
  logic [1:0] sw_raw;
  logic [1:0] limit_hit;

  assign sw_raw = {jockey_r, jockey_l};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_limit_sync
      logic meta_reg;
      logic sync_reg;

      // Two-flop synchroniser for one asynchronous limit input
      always_ff @(posedge sclk) begin
        if (s_rst) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= sw_raw[gi];
          sync_reg <= meta_reg;
        end
      end

      assign limit_hit[gi] = ~sync_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  logic [2:0]       state_reg,      state_next;
  logic [PER_W-1:0] phase_reg,      phase_next;
  logic [PER_W-1:0] period_reg,     period_next;
  logic [CNT_W-1:0] remaining_reg,  remaining_next;
  logic [CNT_W-1:0] step_cnt_reg,   step_cnt_next;
  logic             direct_reg,     direct_next;
  logic             step_out_reg,   step_out_next;
  logic [1:0]       status_reg,     status_next;
  logic             abort_pend_reg, abort_pend_next;
  logic             cmd_ready_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             accept;
  logic             limit_active;
  logic             cmd_limit;
  logic             stop_abort;
  logic [PER_W-1:0] period_eff;
  logic [PER_W-1:0] lo_load;
  logic             busy_next;

  // A command is taken only while the registered ready is high, so the first
  // cycle after reset never accepts a command.
  assign accept = cmd_valid & cmd_ready_reg;

  // The limit that matters is the one we are travelling toward.
  assign limit_active = direct_reg ? limit_hit[1] : limit_hit[0];
  assign cmd_limit    = cmd_dir    ? limit_hit[1] : limit_hit[0];

  // An abort raised this cycle acts at a check point as if it were already pending.
  assign stop_abort = abort_pend_reg | abort;

  // Short periods are stretched so that every pulse keeps a low gap.
  assign period_eff = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;

  // The low phase lasts (period - PULSE_W) cycles.
  assign lo_load = period_reg - LO_BIAS;

  // Next-state and datapath decode for the move sequencer
  always_comb begin
    state_next      = state_reg;
    phase_next      = phase_reg;
    period_next     = period_reg;
    remaining_next  = remaining_reg;
    step_cnt_next   = step_cnt_reg;
    direct_next     = direct_reg;
    step_out_next   = 1'b0;
    status_next     = status_reg;
    abort_pend_next = abort_pend_reg;

    case (state_reg)
      ST_IDLE: begin
        // Abort while idle is ignored. An abort in the same cycle as a command
        // does not block the accept.
        if (accept) begin
          direct_next     = cmd_dir;
          step_cnt_next   = '0;
          status_next     = STAT_OK;
          abort_pend_next = 1'b0;
          remaining_next  = cmd_steps;
          period_next     = period_eff;
          phase_next      = SETUP_LOAD;
          if (cmd_steps == '0) begin
            state_next = ST_DONE;
          end else if (cmd_limit) begin
            state_next  = ST_DONE;
            status_next = STAT_LIMIT;
          end else begin
            state_next = ST_SETUP;
          end
        end
      end

      ST_SETUP: begin
        if (stop_abort) begin
          state_next  = ST_DONE;
          status_next = STAT_ABORT;
        end else if (limit_active) begin
          state_next  = ST_DONE;
          status_next = STAT_LIMIT;
        end else if (phase_reg == '0) begin
          state_next     = ST_STEP_HI;
          step_out_next  = 1'b1;
          phase_next     = PULSE_LOAD;
          remaining_next = remaining_reg - 1'b1;
          step_cnt_next  = step_cnt_reg + 1'b1;
        end else begin
          phase_next = phase_reg - 1'b1;
        end
      end

      ST_STEP_HI: begin
        // A pulse always runs its full width. Abort is only remembered here.
        if (abort) begin
          abort_pend_next = 1'b1;
        end
        if (phase_reg == '0) begin
          state_next = ST_STEP_LO;
          phase_next = lo_load;
        end else begin
          step_out_next = 1'b1;
          phase_next    = phase_reg - 1'b1;
        end
      end

      ST_STEP_LO: begin
        if (stop_abort) begin
          state_next  = ST_DONE;
          status_next = STAT_ABORT;
        end else if (limit_active) begin
          state_next  = ST_DONE;
          status_next = STAT_LIMIT;
        end else if (phase_reg == '0) begin
          if (remaining_reg == '0) begin
            state_next  = ST_DONE;
            status_next = STAT_OK;
          end else begin
            state_next     = ST_STEP_HI;
            step_out_next  = 1'b1;
            phase_next     = PULSE_LOAD;
            remaining_next = remaining_reg - 1'b1;
            step_cnt_next  = step_cnt_reg + 1'b1;
          end
        end else begin
          phase_next = phase_reg - 1'b1;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy_next = (state_next == ST_SETUP) ||
                     (state_next == ST_STEP_HI) ||
                     (state_next == ST_STEP_LO);

  // FSM, timers and counters. Reset drops step_out at once and cancels any move.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_reg      <= ST_IDLE;
      phase_reg      <= '0;
      period_reg     <= '0;
      remaining_reg  <= '0;
      step_cnt_reg   <= '0;
      direct_reg     <= 1'b0;
      step_out_reg   <= 1'b0;
      status_reg     <= STAT_OK;
      abort_pend_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      period_reg     <= period_next;
      remaining_reg  <= remaining_next;
      step_cnt_reg   <= step_cnt_next;
      direct_reg     <= direct_next;
      step_out_reg   <= step_out_next;
      status_reg     <= status_next;
      abort_pend_reg <= abort_pend_next;
    end
  end

  // Handshake and status flags, registered from the next state
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      cmd_ready_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      cmd_ready_reg <= (state_next == ST_IDLE);
      busy_reg      <= busy_next;
      done_reg      <= (state_next == ST_DONE);
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign direct    = direct_reg;
  assign step_out  = step_out_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign status    = status_reg;
  assign step_cnt  = step_cnt_reg;

endmodule

// File: tb/tb_stepper_move_seq.sv
// Testbench for stepper_move_seq. Directed scenarios plus random commands are
// checked against a timeline model. The model derives pulse times, the done
// cycle and the status from the move rules.
module tb_stepper_move_seq;
  localparam int CNT_W     = 16;
  localparam int PER_W     = 16;
  localparam int SETUP_CYC = 4;
  localparam int PULSE_W   = 2;
  localparam int MAXC      = 400;
  localparam int NO_EV     = -1000;

  logic             sclk = 1'b0;
  logic             s_rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [PER_W-1:0] cmd_period;
  logic             abort;
  logic             jockey_l;
  logic             jockey_r;
  logic             direct;
  logic             step_out;
  logic             busy;
  logic             done;
  logic [1:0]       status;
  logic [CNT_W-1:0] step_cnt;

  int total = 0;
  int bad   = 0;

  // Model results for the command under test
  int m_done;
  int m_stat;
  int m_cnt;
  bit exp_hi [0:MAXC-1];

  always #5 sclk = ~sclk;

  stepper_move_seq #(
    .CNT_W(CNT_W), .PER_W(PER_W), .SETUP_CYC(SETUP_CYC), .PULSE_W(PULSE_W)
  ) dut (
    .sclk(sclk), .s_rst(s_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .abort(abort), .jockey_l(jockey_l), .jockey_r(jockey_r), .direct(direct),
    .step_out(step_out), .busy(busy), .done(done), .status(status),
    .step_cnt(step_cnt)
  );

  // Cycles where an early stop is evaluated: the setup window and low gaps
  function automatic bit is_check(input int c, input int p);
    if (c <= SETUP_CYC) return 1'b1;
    return ((c - SETUP_CYC - 1) % p) >= PULSE_W;
  endfunction

  // Timeline model. Cycle 0 presents the command. Pulse k rises at
  // SETUP_CYC+1+k*P. A stop seen at a check cycle ends the move one cycle later.
  task automatic model(input int steps, input int per, input int ab_c, input int lim_c);
    int  p;
    int  prev;
    int  idx;
    bit  fin;
    p = (per < PULSE_W + 1) ? PULSE_W + 1 : per;
    for (int i = 0; i < MAXC; i++) exp_hi[i] = 1'b0;
    m_cnt  = 0;
    m_done = -1;
    m_stat = 0;
    fin    = 1'b0;
    if (steps == 0) begin
      m_done = 1; m_stat = 0; fin = 1'b1;
    end else if (lim_c != NO_EV && lim_c + 2 <= 0) begin
      m_done = 1; m_stat = 1; fin = 1'b1;
    end
    for (int c = 1; c < MAXC && !fin; c++) begin
      prev = c - 1;
      if (prev >= 1 && is_check(prev, p) && ab_c >= 1 && ab_c <= prev) begin
        m_done = c; m_stat = 2; fin = 1'b1;
      end else if (prev >= 1 && is_check(prev, p) && lim_c != NO_EV && prev >= lim_c + 2) begin
        m_done = c; m_stat = 1; fin = 1'b1;
      end else if (c > SETUP_CYC && ((c - SETUP_CYC - 1) % p) == 0) begin
        idx = (c - SETUP_CYC - 1) / p;
        if (idx == steps) begin
          m_done = c; m_stat = 0; fin = 1'b1;
        end else begin
          m_cnt++;
          for (int j = 0; j < PULSE_W; j++) if (c + j < MAXC) exp_hi[c + j] = 1'b1;
        end
      end
    end
  endtask

  task automatic set_limit(input bit dir, input logic v);
    if (dir) jockey_r = v;
    else     jockey_l = v;
  endtask

  // Issue one command and follow it to done, checking against the model
  task automatic run_cmd(input string name, input bit dir, input int steps, input int per,
                         input int ab_c, input int lim_c, input bit toggle_other);
    int         got_done;
    int         mism_hi;
    int         mism_busy;
    logic       got_dir1;
    logic [1:0] got_stat;
    int         got_cnt;
    model(steps, per, ab_c, lim_c);
    if (lim_c != NO_EV && lim_c < 0) begin
      @(posedge sclk); #1;
      set_limit(dir, 1'b0);
      repeat (2) @(posedge sclk);
    end
    @(posedge sclk); #1;
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_steps  = CNT_W'(steps);
    cmd_period = PER_W'(per);
    abort      = (ab_c == 0);
    @(negedge sclk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_at_cycle0 got=%b want=1", name, cmd_ready);
    end
    mism_hi   = (step_out !== 1'b0) ? 1 : 0;
    mism_busy = (busy !== 1'b0) ? 1 : 0;
    got_done  = -1;
    got_dir1  = 1'bx;
    got_stat  = 2'bxx;
    got_cnt   = -1;
    for (int k = 1; k < MAXC; k++) begin
      @(posedge sclk); #1;
      cmd_valid  = 1'b0;
      cmd_dir    = 1'($urandom_range(0, 1));
      cmd_steps  = CNT_W'($urandom);
      cmd_period = PER_W'($urandom);
      abort      = (k == ab_c);
      if (lim_c != NO_EV && k >= lim_c) set_limit(dir, 1'b0);
      if (toggle_other) set_limit(!dir, 1'($urandom_range(0, 1)));
      @(negedge sclk);
      if (step_out !== exp_hi[k]) mism_hi++;
      if (busy !== (k < m_done)) mism_busy++;
      if (k == 1) got_dir1 = direct;
      if (done === 1'b1) begin
        got_done = k;
        got_stat = status;
        got_cnt  = int'(step_cnt);
        break;
      end
    end
    abort = 1'b0;
    if (lim_c != NO_EV || toggle_other) begin
      jockey_l = 1'b1;
      jockey_r = 1'b1;
      repeat (3) @(posedge sclk);
    end
    $display("cmd %-10s dir=%0d steps=%0d per=%0d abort@%0d limit@%0d -> done@%0d status=%0d cnt=%0d",
             name, dir, steps, per, ab_c, lim_c, got_done, got_stat, got_cnt);
    total++;
    if (got_done != m_done) begin
      bad++;
      $display("FAIL %s done_cycle got=%0d want=%0d (-1 = no done within bound)", name, got_done, m_done);
    end
    total++;
    if (got_stat !== 2'(m_stat)) begin
      bad++;
      $display("FAIL %s status got=%0d want=%0d", name, got_stat, m_stat);
    end
    total++;
    if (got_cnt != m_cnt) begin
      bad++;
      $display("FAIL %s step_cnt got=%0d want=%0d", name, got_cnt, m_cnt);
    end
    total++;
    if (got_dir1 !== dir) begin
      bad++;
      $display("FAIL %s direct_cycle1 got=%b want=%b", name, got_dir1, dir);
    end
    total++;
    if (mism_hi != 0) begin
      bad++;
      $display("FAIL %s step_out_trace mismatched_cycles got=%0d want=0", name, mism_hi);
    end
    total++;
    if (mism_busy != 0) begin
      bad++;
      $display("FAIL %s busy_trace mismatched_cycles got=%0d want=0", name, mism_busy);
    end
  endtask

  task automatic test_reset();
    s_rst     = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_steps = '0;
    cmd_period = '0;
    abort     = 1'b0;
    jockey_l  = 1'b1;
    jockey_r  = 1'b1;
    repeat (5) @(posedge sclk);
    @(negedge sclk);
    total++;
    if ({cmd_ready, direct, step_out, busy, done, status, step_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", {cmd_ready, direct, step_out, busy, done, status, step_cnt});
    end
    s_rst = 1'b0;
    @(negedge sclk);
    total++;
    if (cmd_ready !== 1'b1 || {direct, step_out, busy, done, status, step_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_release ready=%b others=%b want ready=1 others=0",
               cmd_ready, {direct, step_out, busy, done, status, step_cnt});
    end
    $display("reset released, cmd_ready=%b", cmd_ready);
  endtask

  task automatic test_reset_mid_move();
    int seen;
    @(posedge sclk); #1;
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd3; cmd_period = 16'd5;
    for (int k = 1; k <= SETUP_CYC + 1; k++) begin
      @(posedge sclk); #1;
      cmd_valid = 1'b0;
    end
    @(negedge sclk);
    total++;
    if (step_out !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pulse_before got=%b want=1", step_out);
    end
    s_rst = 1'b1;
    @(negedge sclk);
    total++;
    if ({step_out, busy, done, step_cnt} !== '0) begin
      bad++;
      $display("FAIL midreset_after got=%b want=0", {step_out, busy, done, step_cnt});
    end
    s_rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge sclk);
      if (done !== 1'b0 || step_out !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midreset_quiet activity_cycles got=%0d want=0", seen);
    end
    $display("reset mid-move checked");
  endtask

  task automatic test_normal();
    run_cmd("normal", 1'b1, 3, 5, NO_EV, NO_EV, 1'b0);
  endtask

  task automatic test_clamp_zero();
    run_cmd("clamp1", 1'b1, 2, 1, NO_EV, NO_EV, 1'b0);
    run_cmd("clamp0", 1'b0, 3, 0, NO_EV, NO_EV, 1'b0);
    run_cmd("zero", 1'b1, 0, 5, NO_EV, NO_EV, 1'b0);
  endtask

  task automatic test_limit();
    run_cmd("limit", 1'b1, 10, 5, NO_EV, 12, 1'b1);
    run_cmd("startlim", 1'b0, 4, 5, NO_EV, -3, 1'b0);
  endtask

  task automatic test_abort();
    run_cmd("abort", 1'b1, 5, 5, 10, NO_EV, 1'b0);
    run_cmd("abort_acc", 1'b0, 2, 3, 0, NO_EV, 1'b0);
    run_cmd("abort_set", 1'b1, 4, 4, 2, NO_EV, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_cmd("b2b_a", 1'b0, 2, 4, NO_EV, NO_EV, 1'b0);
    run_cmd("b2b_b", 1'b1, 1, 3, NO_EV, NO_EV, 1'b0);
  endtask

  task automatic test_random();
    int ab_c;
    int lim_c;
    for (int n = 0; n < 40; n++) begin
      ab_c  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : NO_EV;
      lim_c = NO_EV;
      if ($urandom_range(0, 3) == 0)
        lim_c = ($urandom_range(0, 3) == 0) ? -3 : int'($urandom_range(1, 40));
      run_cmd("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 8)), ab_c, lim_c, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_clamp_zero();
    test_limit();
    test_abort();
    test_back_to_back();
    test_reset_mid_move();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
